// File: rtl/icache_nway_pkg.sv
// Shared types and geometry helpers for the N-way instruction cache and its bus interfaces.
package icache_nway_pkg;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } ibus_resp_t;

  typedef enum logic [2:0] {MSIZE1 = 3'd0, MSIZE2 = 3'd1, MSIZE4 = 3'd2, MSIZE8 = 3'd3} msize_t;

  // Burst length encoded as beats minus one.
  typedef enum logic [7:0] {
    MLEN1  = 8'd0,
    MLEN2  = 8'd1,
    MLEN4  = 8'd3,
    MLEN8  = 8'd7,
    MLEN16 = 8'd15
  } mlen_t;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    msize_t      size;
    logic [31:0] addr;
    logic [3:0]  strobe;
    logic [31:0] data;
    mlen_t       len;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] data;
  } cbus_resp_t;

  typedef enum logic [1:0] {I_UNKNOWN, I_INDEX_INVALID, I_HIT_INVALID} icache_inst_t;

  typedef enum logic [1:0] {StInit, StIdle, StFetch} state_t;

  function automatic int unsigned offset_bits(input int unsigned words);
    return $clog2(words);
  endfunction

  function automatic int unsigned index_bits(input int unsigned sets);
    return $clog2(sets);
  endfunction

  function automatic int unsigned tag_bits(input int unsigned sets, input int unsigned words);
    return 32 - $clog2(sets) - $clog2(words) - 2;
  endfunction

  function automatic mlen_t line_len(input int unsigned words);
    case (words)
      4:       return MLEN4;
      8:       return MLEN8;
      default: return MLEN16;
    endcase
  endfunction

endpackage

// File: rtl/icache_nway_plru_tree.sv
// Tree pseudo-LRU: picks a victim by walking the bits from the root and re-points the
// path of a touched way away from it.
module icache_nway_plru_tree #(
  parameter int unsigned WAYS = 4
) (
  input  logic [WAYS-2:0]         bits_in,
  input  logic [$clog2(WAYS)-1:0] touch_way,
  input  logic                    touch_en,
  output logic [WAYS-2:0]         bits_out,
  output logic [$clog2(WAYS)-1:0] victim
);

  localparam int unsigned WayBits = $clog2(WAYS);

  // Padded to WAYS bits so a WayBits-wide node index always fits.
  logic [WAYS-1:0]    tree_in;
  logic [WAYS-1:0]    tree_out;
  logic [WayBits-1:0] node_v;
  logic [WayBits-1:0] node_t;
  logic               unused_pad;

  assign tree_in    = {1'b0, bits_in};
  assign bits_out   = tree_out[WAYS-2:0];
  assign unused_pad = tree_out[WAYS-1];

  always_comb begin
    victim   = '0;
    tree_out = tree_in;
    node_v   = '0;
    node_t   = '0;
    for (int l = 0; l < int'(WayBits); l++) begin
      victim[WayBits-1-l] = tree_in[node_v];
      node_v = (node_v << 1) + WayBits'(1) + WayBits'(tree_in[node_v]);
    end
    if (touch_en) begin
      for (int l = 0; l < int'(WayBits); l++) begin
        tree_out[node_t] = ~touch_way[WayBits-1-l];
        node_t = (node_t << 1) + WayBits'(1) + WayBits'(touch_way[WayBits-1-l]);
      end
    end
  end

endmodule

// File: rtl/icache_nway.sv
// N-way set-associative instruction cache serving a two-word fetch pair; misses refill a
// whole line over the cbus, and an invalidate sweep runs after every reset.
module icache_nway
  import icache_nway_pkg::*;
#(
  parameter int unsigned WAYS           = 4,
  parameter int unsigned SET_NUM        = 64,
  parameter int unsigned WORDS_PER_LINE = 16
) (
  input  logic         clk,
  input  logic         resetn,
  input  ibus_req_t    ireq_1,
  input  ibus_req_t    ireq_2,
  output ibus_resp_t   iresp,
  output cbus_req_t    icreq,
  input  cbus_resp_t   icresp,
  input  icache_inst_t cache_inst
);

  localparam int unsigned OffsetBits = offset_bits(WORDS_PER_LINE);
  localparam int unsigned IndexBits  = index_bits(SET_NUM);
  localparam int unsigned TagBits    = tag_bits(SET_NUM, WORDS_PER_LINE);
  localparam int unsigned WayBits    = $clog2(WAYS);
  localparam int unsigned DataAw     = WayBits + IndexBits + OffsetBits;

  state_t                state_q, state_d;
  logic [IndexBits-1:0]  ctr_q, ctr_d;
  logic [31:0]           target_q, target_d;
  logic [WayBits-1:0]    victim_q, victim_d;
  logic [OffsetBits-1:0] off_q, off_d;
  logic                  data_ok_q, data_ok_d;
  logic [31:0]           rd1_q, rd2_q;

  logic [WAYS-2:0]       plru_q  [SET_NUM];
  logic [WAYS-1:0]       valid_q [SET_NUM];
  logic [TagBits-1:0]    tag_q   [SET_NUM][WAYS];
  logic [31:0]           data_q  [2**DataAw];

  logic [IndexBits-1:0]  idx_1, idx_2, tgt_idx;
  logic [TagBits-1:0]    tag_1, tag_2, tgt_tag;
  logic [OffsetBits-1:0] off_1, off_2;
  logic [WayBits-1:0]    idx_way, way_1, way_2, victim_1, victim_2, victim_f;
  logic [WAYS-1:0]       hit_vec_1, hit_vec_2;
  logic                  hit_1, hit_2;
  logic [WAYS-2:0]       plru_upd_1, plru_upd_2, plru_upd_f;
  logic                  addr_ok, fetch_hit, op_fire, fill_done, beat;
  logic                  unused_bits;

  assign idx_1   = ireq_1.addr[OffsetBits+2 +: IndexBits];
  assign idx_2   = ireq_2.addr[OffsetBits+2 +: IndexBits];
  assign tgt_idx = target_q[OffsetBits+2 +: IndexBits];
  assign tag_1   = ireq_1.addr[31 -: TagBits];
  assign tag_2   = ireq_2.addr[31 -: TagBits];
  assign tgt_tag = target_q[31 -: TagBits];
  assign off_1   = ireq_1.addr[2 +: OffsetBits];
  assign off_2   = ireq_2.addr[2 +: OffsetBits];
  assign idx_way = ireq_1.addr[OffsetBits+IndexBits+2 +: WayBits];

  assign unused_bits = ^{ireq_1.addr[1:0], ireq_2.addr[1:0], target_q[OffsetBits+1:0], victim_f};

  always_comb begin
    hit_vec_1 = '0;
    hit_vec_2 = '0;
    way_1     = '0;
    way_2     = '0;
    for (int w = 0; w < int'(WAYS); w++) begin
      hit_vec_1[w] = valid_q[idx_1][w] && (tag_q[idx_1][w] == tag_1);
      hit_vec_2[w] = valid_q[idx_2][w] && (tag_q[idx_2][w] == tag_2);
      if (hit_vec_1[w]) way_1 = WayBits'(w);
      if (hit_vec_2[w]) way_2 = WayBits'(w);
    end
  end

  assign hit_1 = |hit_vec_1;
  assign hit_2 = |hit_vec_2;

  icache_nway_plru_tree #(.WAYS(WAYS)) u_plru_1 (
    .bits_in   (plru_q[idx_1]),
    .touch_way (way_1),
    .touch_en  (fetch_hit),
    .bits_out  (plru_upd_1),
    .victim    (victim_1)
  );

  icache_nway_plru_tree #(.WAYS(WAYS)) u_plru_2 (
    .bits_in   (plru_q[idx_2]),
    .touch_way (way_2),
    .touch_en  (fetch_hit & ireq_2.valid),
    .bits_out  (plru_upd_2),
    .victim    (victim_2)
  );

  icache_nway_plru_tree #(.WAYS(WAYS)) u_plru_f (
    .bits_in   (plru_q[tgt_idx]),
    .touch_way (victim_q),
    .touch_en  (fill_done),
    .bits_out  (plru_upd_f),
    .victim    (victim_f)
  );

  always_comb begin
    state_d   = state_q;
    ctr_d     = ctr_q;
    target_d  = target_q;
    victim_d  = victim_q;
    off_d     = off_q;
    data_ok_d = 1'b0;
    addr_ok   = 1'b0;
    fetch_hit = 1'b0;
    op_fire   = 1'b0;
    fill_done = 1'b0;
    beat      = 1'b0;
    case (state_q)
      StInit: begin
        ctr_d = ctr_q + 1'b1;
        if (ctr_q == IndexBits'(SET_NUM - 1)) state_d = StIdle;
      end
      StIdle: begin
        if (ireq_1.valid) begin
          if (cache_inst != I_UNKNOWN) begin
            addr_ok = 1'b1;
            op_fire = 1'b1;
          end else if (hit_1 && (hit_2 || !ireq_2.valid)) begin
            addr_ok   = 1'b1;
            fetch_hit = 1'b1;
            data_ok_d = 1'b1;
          end else begin
            // The missing word is latched so ireq may wander while the refill runs.
            state_d  = StFetch;
            off_d    = '0;
            target_d = hit_1 ? ireq_2.addr : ireq_1.addr;
            victim_d = hit_1 ? victim_2 : victim_1;
          end
        end
      end
      StFetch: begin
        if (icresp.ready) begin
          beat  = 1'b1;
          off_d = off_q + 1'b1;
          if (icresp.last) begin
            fill_done = 1'b1;
            state_d   = StIdle;
          end
        end
      end
      default: state_d = StInit;
    endcase
  end

  assign iresp = '{addr_ok: addr_ok, data_ok: data_ok_q, data: {rd2_q, rd1_q}};

  assign icreq = '{
    valid:    (state_q == StFetch),
    is_write: 1'b0,
    size:     MSIZE4,
    addr:     {target_q[31:OffsetBits+2], {(OffsetBits+2){1'b0}}},
    strobe:   4'b0,
    data:     32'b0,
    len:      line_len(WORDS_PER_LINE)
  };

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= StInit;
      ctr_q     <= '0;
      target_q  <= '0;
      victim_q  <= '0;
      off_q     <= '0;
      data_ok_q <= 1'b0;
      for (int s = 0; s < int'(SET_NUM); s++) plru_q[s] <= '0;
    end else begin
      state_q   <= state_d;
      ctr_q     <= ctr_d;
      target_q  <= target_d;
      victim_q  <= victim_d;
      off_q     <= off_d;
      data_ok_q <= data_ok_d;
      // On a same-set pair the second word's update is written last and wins.
      if (fetch_hit) plru_q[idx_1] <= plru_upd_1;
      if (fetch_hit && ireq_2.valid) plru_q[idx_2] <= plru_upd_2;
      if (fill_done) plru_q[tgt_idx] <= plru_upd_f;
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == StInit) valid_q[ctr_q] <= '0;
    if (op_fire) begin
      if (cache_inst == I_INDEX_INVALID) valid_q[idx_1][idx_way] <= 1'b0;
      else if (hit_1) valid_q[idx_1][way_1] <= 1'b0;
    end
    if (fill_done) begin
      valid_q[tgt_idx][victim_q] <= 1'b1;
      tag_q[tgt_idx][victim_q]   <= tgt_tag;
    end
    if (beat) data_q[{victim_q, tgt_idx, off_q}] <= icresp.data;
    rd1_q <= data_q[{way_1, idx_1, off_1}];
    rd2_q <= data_q[{way_2, idx_2, off_2}];
  end

endmodule

// File: tb/tb_icache_nway.sv
// Directed and randomized bench for icache_nway with a behavioural cache and memory model.
module tb_icache_nway;
  import icache_nway_pkg::*;

  localparam int unsigned WAYS = 4;
  localparam int unsigned SETS = 64;
  localparam int unsigned WPL  = 16;
  localparam int unsigned OFFB = 4;
  localparam int unsigned IDXB = 6;

  logic         clk = 1'b0;
  logic         resetn;
  ibus_req_t    ireq_1, ireq_2;
  ibus_resp_t   iresp;
  cbus_req_t    icreq;
  cbus_resp_t   icresp;
  icache_inst_t cache_inst;

  int vectors = 0;
  int errors  = 0;

  bit          mv [SETS][WAYS];
  int unsigned mt [SETS][WAYS];
  bit [WAYS-2:0] mp [SETS];

  always #5 clk = ~clk;

  icache_nway #(.WAYS(WAYS), .SET_NUM(SETS), .WORDS_PER_LINE(WPL)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .ireq_1     (ireq_1),
    .ireq_2     (ireq_2),
    .iresp      (iresp),
    .icreq      (icreq),
    .icresp     (icresp),
    .cache_inst (cache_inst)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [31:0] memw(input logic [31:0] a);
    return a ^ {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  function automatic int m_set(input logic [31:0] a);
    return int'((a >> (OFFB + 2)) % SETS);
  endfunction

  function automatic int unsigned m_tag(input logic [31:0] a);
    return a >> (OFFB + IDXB + 2);
  endfunction

  function automatic int m_way(input logic [31:0] a);
    for (int w = 0; w < int'(WAYS); w++)
      if (mv[m_set(a)][w] && mt[m_set(a)][w] == m_tag(a)) return w;
    return -1;
  endfunction

  // Victim: descend halving the way range, bit=1 selects the upper half.
  function automatic int m_victim(input int s);
    int lo = 0, span = WAYS, node = 0;
    while (span > 1) begin
      span = span / 2;
      if (mp[s][node]) begin lo += span; node = 2 * node + 2; end
      else node = 2 * node + 1;
    end
    return lo;
  endfunction

  task automatic m_touch(input int s, input int way);
    int lo = 0, span = WAYS, node = 0;
    while (span > 1) begin
      span = span / 2;
      if (way >= lo + span) begin mp[s][node] = 1'b0; lo += span; node = 2 * node + 2; end
      else begin mp[s][node] = 1'b1; node = 2 * node + 1; end
    end
  endtask

  task automatic m_clear();
    for (int s = 0; s < int'(SETS); s++) begin
      mp[s] = '0;
      for (int w = 0; w < int'(WAYS); w++) mv[s][w] = 1'b0;
    end
  endtask

  task automatic do_fetch(input logic [31:0] a1, input bit v2, output int nb);
    logic [31:0] a2, line;
    int cyc, w1, w2, s, vict;
    bit done, miss;
    a2 = a1 + 32'd4;
    nb = 0; cyc = 0; done = 1'b0;
    ireq_1 = '{valid: 1'b1, addr: a1};
    ireq_2 = '{valid: v2, addr: a2};
    cache_inst = I_UNKNOWN;
    #1;
    while (!done && cyc < 600) begin
      w1 = m_way(a1);
      w2 = v2 ? m_way(a2) : 0;
      miss = (w1 < 0) || (v2 && w2 < 0);
      if (iresp.addr_ok) begin
        chk("hit_expected", 64'(miss), 64'(0));
        if (v2 && m_set(a1) == m_set(a2)) m_touch(m_set(a2), w2);
        else begin
          m_touch(m_set(a1), w1);
          if (v2) m_touch(m_set(a2), w2);
        end
        tick();
        ireq_1.valid = 1'b0;
        ireq_2.valid = 1'b0;
        chk("data_ok", 64'(iresp.data_ok), 64'(1));
        chk("data_word1", 64'(iresp.data[31:0]), 64'(memw(a1)));
        if (v2) chk("data_word2", 64'(iresp.data[63:32]), 64'(memw(a2)));
        done = 1'b1;
      end else if (icreq.valid) begin
        chk("miss_expected", 64'(miss), 64'(1));
        line = ((w1 < 0) ? a1 : a2) & ~(WPL * 4 - 1);
        chk("burst_addr", 64'(icreq.addr), 64'(line));
        chk("burst_len", 64'(icreq.len), 64'(WPL - 1));
        chk("burst_ctl", 64'({icreq.is_write, icreq.size}), 64'({1'b0, MSIZE4}));
        s = m_set(line);
        vict = m_victim(s);
        for (int b = 0; b < int'(WPL); b++) begin
          while ($urandom_range(3) == 0) begin
            icresp = '0;
            tick();
            cyc++;
          end
          icresp = '{ready: 1'b1, last: (b == int'(WPL) - 1), data: memw(line + 32'(4 * b))};
          tick();
          cyc++;
        end
        icresp = '0;
        mv[s][vict] = 1'b1;
        mt[s][vict] = m_tag(line);
        m_touch(s, vict);
        nb++;
      end else begin
        tick();
        cyc++;
      end
    end
    chk("fetch_done", 64'(done), 64'(1));
    ireq_1.valid = 1'b0;
    ireq_2.valid = 1'b0;
  endtask

  task automatic do_op(input icache_inst_t op, input logic [31:0] a);
    int w;
    ireq_1 = '{valid: 1'b1, addr: a};
    ireq_2 = '{valid: 1'b0, addr: a + 32'd4};
    cache_inst = op;
    #1;
    chk("op_addr_ok", 64'(iresp.addr_ok), 64'(1));
    if (op == I_INDEX_INVALID) mv[m_set(a)][(a >> (OFFB + IDXB + 2)) % WAYS] = 1'b0;
    else begin
      w = m_way(a);
      if (w >= 0) mv[m_set(a)][w] = 1'b0;
    end
    tick();
    ireq_1.valid = 1'b0;
    cache_inst = I_UNKNOWN;
    chk("op_no_data_ok", 64'(iresp.data_ok), 64'(0));
  endtask

  initial begin
    int nb;
    logic [31:0] a;
    resetn = 1'b0;
    ireq_1 = '0;
    ireq_2 = '0;
    icresp = '0;
    cache_inst = I_UNKNOWN;
    m_clear();

    // Reset state and the post-reset sweep length.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_addr_ok", 64'(iresp.addr_ok), 64'(0));
      chk("rst_icreq_valid", 64'(icreq.valid), 64'(0));
      chk("rst_data_ok", 64'(iresp.data_ok), 64'(0));
    end
    ireq_1 = '{valid: 1'b1, addr: 32'hBFC0_0000};
    cache_inst = I_INDEX_INVALID;
    resetn = 1'b1;
    #1;
    for (int i = 0; i < int'(SETS); i++) begin
      chk("sweep_addr_ok_low", 64'(iresp.addr_ok), 64'(0));
      tick();
    end
    chk("sweep_done_addr_ok", 64'(iresp.addr_ok), 64'(1));
    tick();
    ireq_1.valid = 1'b0;
    cache_inst = I_UNKNOWN;
    chk("sweep_op_no_data_ok", 64'(iresp.data_ok), 64'(0));

    // Cold pair in one line, then a cold line-crossing pair.
    do_fetch(32'hBFC0_0000, 1'b1, nb);
    chk("t2_bursts", 64'(nb), 64'(1));
    do_fetch(32'hBFC0_0000, 1'b1, nb);
    chk("t2_rehit", 64'(nb), 64'(0));
    do_fetch(32'hBFC0_103C, 1'b1, nb);
    chk("t3_bursts", 64'(nb), 64'(2));

    // Fill set 8 with four tags, touch them in order, a fifth tag evicts the first.
    for (int k = 0; k < 4; k++) do_fetch(((32'hBFC10 + 32'(k)) << 12) | (32'd8 << 6), 1'b0, nb);
    for (int k = 0; k < 4; k++) begin
      do_fetch(((32'hBFC10 + 32'(k)) << 12) | (32'd8 << 6), 1'b0, nb);
      chk("t4_touch_hit", 64'(nb), 64'(0));
    end
    do_fetch((32'hBFC14 << 12) | (32'd8 << 6), 1'b0, nb);
    chk("t4_fifth_fill", 64'(nb), 64'(1));
    do_fetch((32'hBFC10 << 12) | (32'd8 << 6), 1'b0, nb);
    chk("t4_tag0_evicted", 64'(nb), 64'(1));

    // Hit-invalidate forces a refill.
    do_fetch(32'hBFC0_0100, 1'b1, nb);
    do_op(I_HIT_INVALID, 32'hBFC0_0100);
    do_fetch(32'hBFC0_0100, 1'b1, nb);
    chk("t5_refill", 64'(nb), 64'(1));

    // Reset in the middle of a refill.
    a = 32'hBFC2_0200;
    ireq_1 = '{valid: 1'b1, addr: a};
    ireq_2 = '{valid: 1'b1, addr: a + 32'd4};
    for (int i = 0; i < 10 && !icreq.valid; i++) tick();
    chk("t6_burst_start", 64'(icreq.valid), 64'(1));
    for (int b = 0; b < 5; b++) begin
      icresp = '{ready: 1'b1, last: 1'b0, data: memw(a + 32'(4 * b))};
      tick();
    end
    resetn = 1'b0;
    #1;
    chk("t6_valid_drop", 64'(icreq.valid), 64'(0));
    chk("t6_addr_ok_low", 64'(iresp.addr_ok), 64'(0));
    icresp = '0;
    ireq_1.valid = 1'b0;
    ireq_2.valid = 1'b0;
    m_clear();
    for (int i = 0; i < 3; i++) tick();
    resetn = 1'b1;
    for (int i = 0; i < int'(SETS) + 1; i++) tick();
    do_fetch(a, 1'b1, nb);
    chk("t6_full_refill", 64'(nb), 64'(1));

    // Random mix over a small address pool to exercise hits, evictions and invalidates.
    for (int i = 0; i < 200; i++) begin
      a = ((32'hBFC00 + 32'($urandom_range(5))) << 12) | (32'($urandom_range(3)) << 6)
          | (32'($urandom_range(15)) << 2);
      if ($urandom_range(9) < 8) do_fetch(a, ($urandom_range(3) != 0), nb);
      else do_op(($urandom_range(1) == 0) ? I_INDEX_INVALID : I_HIT_INVALID, a);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
